tmds_encoder_8b10b: RTL and testbench



---
 rtl/tmds_pkg.sv | 19 +
 rtl/tmds_encoder_8b10b_qm.sv | 53 +++++
 rtl/tmds_encoder_8b10b.sv | 89 ++++++++
 tb/tb_tmds_encoder_8b10b.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS tokens, TERC4 table (TMDS_TERC4_EN) and popcount helper.
package tmds_pkg;
  localparam logic [9:0] RST_TOK = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK [0:3] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] TERC4 [0:15] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
`endif
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'b000, v[i]};
  endfunction
endpackage

// File: rtl/tmds_encoder_8b10b_qm.sv
// tmds_qm_stage: transition-minimised q_m plus registered side-band; island/aux under TMDS_TERC4_EN.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
`ifdef TMDS_TERC4_EN
  input  logic       i_island,
  input  logic [3:0] i_aux,
  output logic       o_island,
  output logic [3:0] o_aux,
`endif
  output logic [8:0] o_qm,
  output logic [3:0] o_n1q,
  output logic       o_de,
  output logic [1:0] o_ctrl
);
  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [8:0] w_qm;
  assign w_n1d  = popcount8(i_data);
  assign w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !i_data[0]);
  always_comb begin
    w_qm    = '0;
    w_qm[0] = i_data[0];
    for (int i = 1; i < 8; i++) w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i]) : w_qm[i-1] ^ i_data[i];
    w_qm[8] = ~w_xnor;
  end
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      o_qm   <= '0;
      o_n1q  <= '0;
      o_de   <= 1'b0;
      o_ctrl <= 2'b00;
`ifdef TMDS_TERC4_EN
      o_island <= 1'b0;
      o_aux    <= '0;
`endif
    end else begin
      o_qm   <= w_qm;
      o_n1q  <= popcount8(w_qm[7:0]);
      o_de   <= i_de;
      o_ctrl <= i_ctrl;
`ifdef TMDS_TERC4_EN
      o_island <= i_island;
      o_aux    <= i_aux;
`endif
    end
  end
endmodule

// File: rtl/tmds_encoder_8b10b.sv
// tmds_encoder_8b10b: two-stage DVI TMDS channel encoder with running disparity.
// Defining TMDS_TERC4_EN adds island/aux ports for HDMI TERC4 data-island symbols.
module tmds_encoder_8b10b
  import tmds_pkg::*;
#(
  parameter int DISP_W = 5
) (
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              de,
  input  logic [7:0]        data,
  input  logic [1:0]        ctrl,
`ifdef TMDS_TERC4_EN
  input  logic              island,
  input  logic [3:0]        aux,
`endif
  output logic [9:0]        tmds,
  output logic [DISP_W-1:0] disp
);
  logic [8:0]        w_qm;
  logic [3:0]        w_n1q;
  logic              w_de;
  logic [1:0]        w_ctrl;
  logic [DISP_W-1:0] w_diff, w_two, w_cnt;
  logic [9:0]        w_tmds;
  logic              w_pos, w_neg, w_case_a, w_case_b;
  logic [9:0]        r_tmds;
  logic [DISP_W-1:0] r_cnt;
`ifdef TMDS_TERC4_EN
  logic              w_island;
  logic [3:0]        w_aux;
`endif
  tmds_qm_stage u_qm (
    .clk_pix (clk_pix),
    .rst     (rst),
    .i_de    (de),
    .i_data  (data),
    .i_ctrl  (ctrl),
`ifdef TMDS_TERC4_EN
    .i_island(island),
    .i_aux   (aux),
    .o_island(w_island),
    .o_aux   (w_aux),
`endif
    .o_qm    (w_qm),
    .o_n1q   (w_n1q),
    .o_de    (w_de),
    .o_ctrl  (w_ctrl)
  );
  // w_diff = N1q - N0q = 2*N1q - 8; sign tests read the MSB of the two's-complement count
  assign w_diff   = DISP_W'({w_n1q, 1'b0}) - DISP_W'(8);
  assign w_two    = DISP_W'({w_qm[8], 1'b0});
  assign w_pos    = !r_cnt[DISP_W-1] && (r_cnt != '0);
  assign w_neg    = r_cnt[DISP_W-1];
  assign w_case_a = (r_cnt == '0) || (w_n1q == 4'd4);
  assign w_case_b = (w_pos && w_n1q > 4'd4) || (w_neg && w_n1q < 4'd4);
  always_comb begin
    w_tmds = CTRL_TOK[w_ctrl];
    w_cnt  = '0;
`ifdef TMDS_TERC4_EN
    if (w_island) w_tmds = TERC4[w_aux];
`endif
    if (w_de) begin
      if (w_case_a) begin
        w_tmds = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
        w_cnt  = w_qm[8] ? r_cnt + w_diff : r_cnt - w_diff;
      end else if (w_case_b) begin
        w_tmds = {1'b1, w_qm[8], ~w_qm[7:0]};
        w_cnt  = r_cnt + w_two - w_diff;
      end else begin
        w_tmds = {1'b0, w_qm[8], w_qm[7:0]};
        w_cnt  = r_cnt + w_diff + w_two - DISP_W'(2);
      end
    end
  end
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_tmds <= RST_TOK;
      r_cnt  <= '0;
    end else begin
      r_tmds <= w_tmds;
      r_cnt  <= w_cnt;
    end
  end
  assign tmds = r_tmds;
  assign disp = r_cnt;
  a_disp_bound: assert property (@(posedge clk_pix) disable iff (rst)
    $signed(r_cnt) <= $signed(DISP_W'(10)) && $signed(r_cnt) >= $signed(DISP_W'(-10)) && !r_cnt[0]);
endmodule

// File: tb/tb_tmds_encoder_8b10b.sv
// tb_tmds_encoder_8b10b: scoreboard bench with an independent TMDS model and decoder.
module tb_tmds_encoder_8b10b;
  logic       clk_pix = 1'b0;
  logic       rst = 1'b1;
  logic       de = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ctrl = '0;
  logic       island = 1'b0;
  logic [3:0] aux = '0;
  logic [9:0] tmds;
  logic [4:0] disp;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt = 0;
  string phase = "reset";
  typedef struct {
    logic [9:0] t;
    int         c;
    bit         v;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];
  localparam logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  tmds_encoder_8b10b #(.DISP_W(5)) dut (
    .clk_pix(clk_pix),
    .rst    (rst),
    .de     (de),
    .data   (data),
    .ctrl   (ctrl),
`ifdef TMDS_TERC4_EN
    .island (island),
    .aux    (aux),
`endif
    .tmds   (tmds),
    .disp   (disp)
  );
  always #5 clk_pix = ~clk_pix;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask
  function automatic logic [9:0] model(input bit d_e, input logic [7:0] d, input logic [1:0] c,
                                       input bit isl, input logic [3:0] ax);
    int n1, n1q, n0q;
    bit xn, q8;
    logic [7:0] qm;
    if (!d_e) begin
      m_cnt = 0;
      return isl ? TERC[ax] : CTL[c];
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    n1q = 0;
    for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
    n0q = 8 - n1q;
    if (m_cnt == 0 || n1q == n0q) begin
      m_cnt += q8 ? (n1q - n0q) : (n0q - n1q);
      return {~q8, q8, q8 ? qm : ~qm};
    end
    if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
      m_cnt += 2 * int'(q8) + (n0q - n1q);
      return {1'b1, q8, ~qm};
    end
    m_cnt += -2 * int'(!q8) + (n1q - n0q);
    return {1'b0, q8, qm};
  endfunction
  function automatic logic [7:0] decode(input logic [9:0] t);
    logic [7:0] q, o;
    q = t[9] ? ~t[7:0] : t[7:0];
    o[0] = q[0];
    for (int i = 1; i < 8; i++) o[i] = t[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return o;
  endfunction
  task automatic step(input bit r, input bit d_e, input logic [7:0] d, input logic [1:0] c,
                      input bit isl, input logic [3:0] ax);
    exp_t e, o;
    int sd;
    @(negedge clk_pix);
    rst = r; de = d_e; data = d; ctrl = c; island = isl; aux = ax;
    if (r) begin
      m_cnt = 0;
      sb.delete();
      sb.push_back('{CTL[0], 0, 1'b0, 8'h00});
      sb.push_back('{CTL[0], 0, 1'b0, 8'h00});
    end else begin
      e.t = model(d_e, d, c, isl, ax);
      e.c = m_cnt;
      e.v = d_e;
      e.d = d;
      sb.push_back(e);
    end
    @(posedge clk_pix);
    #1;
    if (sb.size() == 2) begin
      o = sb.pop_front();
      sd = int'($signed(disp));
      chk({phase, ".tmds"}, int'(tmds), int'(o.t));
      chk({phase, ".disp"}, sd, o.c);
      if (o.v) begin
        chk({phase, ".decode"}, int'(decode(tmds)), int'(o.d));
        chk({phase, ".bound"}, int'(sd <= 10 && sd >= -10), 1);
      end
    end
  endtask
  initial begin
    phase = "reset";
    repeat (3) step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    repeat (3) step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    phase = "zero";
    repeat (3) step(1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 4'h0);
    phase = "ctrl";
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'($urandom), 2'(c), 1'b0, 4'h0);
`ifdef TMDS_TERC4_EN
    phase = "terc4";
    for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 8'($urandom), 2'(a), 1'b1, 4'(a));
    phase = "terc4_de";
    repeat (20) step(1'b0, 1'b1, 8'($urandom), 2'($urandom), 1'b1, 4'($urandom));
`endif
    phase = "rand";
    for (int i = 0; i < 10000; i++)
      step(i == 5000, (i % 64) != 63, 8'($urandom), 2'($urandom), 1'b0, 4'h0);
    phase = "drain";
    repeat (2) step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
